// File: rtl/sc_regshiftseq_pkg.sv
// Shared definitions for the sequential shift register stage: FSM state
// encodings and shift-direction constants.
package sc_regshiftseq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

endpackage

// File: rtl/sc_regshiftseq_onebit.sv
// Combinational single-bit shifter: left shift fills zero, right shift fills
// zero or replicates the MSB; also returns the bit that falls off the end.
module sc_regshiftseq_onebit
    import sc_regshiftseq_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 32
) (
    input  logic [DATAWIDTH_BUS-1:0] data_i,
    input  logic                     dir_i,
    input  logic                     arith_i,
    output logic [DATAWIDTH_BUS-1:0] data_o,
    output logic                     carry_o
);

    logic fill;

    always_comb begin
        fill    = arith_i & data_i[DATAWIDTH_BUS-1];
        data_o  = data_i;
        carry_o = 1'b0;
        if (dir_i == SHIFT_LEFT) begin
            data_o  = {data_i[DATAWIDTH_BUS-2:0], 1'b0};
            carry_o = data_i[DATAWIDTH_BUS-1];
        end else begin
            data_o  = {fill, data_i[DATAWIDTH_BUS-1:1]};
            carry_o = data_i[0];
        end
    end

endmodule

// File: rtl/sc_regshiftseq.sv
// Sequential shift register: loads a bus word, then shifts it one bit per
// falling clock edge for a programmable count, bracketed by Busy/Done.
module sc_regshiftseq
    import sc_regshiftseq_pkg::*;
#(
    parameter int                      DATAWIDTH_BUS      = 32,
    parameter int                      SHIFTAMT_WIDTH     = 5,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGSHIFT_INIT = '0
) (
    input  logic                      SC_RegSHIFTSEQ_CLOCK_50,
    input  logic                      SC_RegSHIFTSEQ_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0]  SC_RegSHIFTSEQ_DataBUS_In,
    input  logic                      SC_RegSHIFTSEQ_Load_InHigh,
    input  logic                      SC_RegSHIFTSEQ_Start_InHigh,
    input  logic                      SC_RegSHIFTSEQ_Dir_In,
    input  logic                      SC_RegSHIFTSEQ_Arith_In,
    input  logic [SHIFTAMT_WIDTH-1:0] SC_RegSHIFTSEQ_ShiftAmt_In,
    output logic [DATAWIDTH_BUS-1:0]  SC_RegSHIFTSEQ_DataBUS_Out,
    output logic                      SC_RegSHIFTSEQ_Busy_Out,
    output logic                      SC_RegSHIFTSEQ_Done_Out,
    output logic                      SC_RegSHIFTSEQ_Carry_Out,
    output logic                      SC_RegSHIFTSEQ_Zero_Out
);

    state_e                     state_q, state_d;
    logic [DATAWIDTH_BUS-1:0]   reg_q, reg_d;
    logic [SHIFTAMT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                       carry_q, carry_d;
    logic                       dir_q, dir_d;
    logic                       arith_q, arith_d;

    logic [DATAWIDTH_BUS-1:0]   shifted;
    logic                       shifted_out;

    logic start_req;
    assign start_req = SC_RegSHIFTSEQ_Start_InHigh & ~SC_RegSHIFTSEQ_Load_InHigh;

    sc_regshiftseq_onebit #(
        .DATAWIDTH_BUS(DATAWIDTH_BUS)
    ) u_onebit (
        .data_i  (reg_q),
        .dir_i   (dir_q),
        .arith_i (arith_q),
        .data_o  (shifted),
        .carry_o (shifted_out)
    );

    // All state moves on the falling edge, matching the other datapath registers.
    always_ff @(negedge SC_RegSHIFTSEQ_CLOCK_50) begin
        if (SC_RegSHIFTSEQ_Reset_InHigh) begin
            state_q <= IDLE;
            reg_q   <= DATA_REGSHIFT_INIT;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            dir_q   <= SHIFT_LEFT;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_req) begin
                    state_d = (SC_RegSHIFTSEQ_ShiftAmt_In == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == SHIFTAMT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state; the counter is only decremented in SHIFT, where it is >= 1.
    always_comb begin
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        if (state_q == IDLE) begin
            if (SC_RegSHIFTSEQ_Load_InHigh) begin
                reg_d   = SC_RegSHIFTSEQ_DataBUS_In;
                carry_d = 1'b0;
            end else if (SC_RegSHIFTSEQ_Start_InHigh) begin
                dir_d   = SC_RegSHIFTSEQ_Dir_In;
                arith_d = SC_RegSHIFTSEQ_Arith_In;
                cnt_d   = SC_RegSHIFTSEQ_ShiftAmt_In;
            end
        end else if (state_q == SHIFT) begin
            reg_d   = shifted;
            carry_d = shifted_out;
            cnt_d   = cnt_q - SHIFTAMT_WIDTH'(1);
        end
    end

    always_comb begin
        SC_RegSHIFTSEQ_DataBUS_Out = reg_q;
        SC_RegSHIFTSEQ_Busy_Out    = (state_q == SHIFT);
        SC_RegSHIFTSEQ_Done_Out    = (state_q == DONE);
        SC_RegSHIFTSEQ_Carry_Out   = carry_q;
        SC_RegSHIFTSEQ_Zero_Out    = (reg_q == '0);
    end

endmodule
